normalize_control: RTL and testbench
====================================

NORMALIZE_CONTROL -- requirements
Module: normalize_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request to normalize; sampled only in IDLE.
REQ-004 SHALL have port exponent_in, input, 8 bits: biased exponent, latched on accepted start.
REQ-005 SHALL have port mantissa_in, input, 25 bits: bit24 is carry, bit23 is hidden bit; latched on accepted start.
REQ-006 SHALL have port exp_adj_value, output, 8 bits: exponent register, driven to the external exponent increase/decrease unit.
REQ-007 SHALL have port exp_adj_amount, output, 8 bits: adjust magnitude.
REQ-008 SHALL have port exp_adj_aluop, output, 4 bits: 4'b0000 is add, 4'b0011 is subtract.
REQ-009 SHALL have port exp_adj_enable, output, 1 bit: 1 only in cycles where a shift is applied.
REQ-010 SHALL have port exp_adj_result, input, 8 bits: adjusted exponent returned by the unit (combinational).
REQ-011 SHALL have ports exponent_out (output, 8 bits) and mantissa_out (output, 25 bits): normalized result registers.
REQ-012 SHALL have ports busy, done, overflow and underflow, each output, 1 bit: status.

Function
REQ-013 SHALL implement states IDLE, NORM and DONE.
REQ-014 IDLE: start=1 SHALL latch the inputs into exp_reg and man_reg, clear overflow and underflow, and go to NORM; busy=1 in NORM and DONE.
REQ-015 NORM, man_reg==0: SHALL set exp_reg=0 and go to DONE.
REQ-016 NORM, bit24=1, exp_reg<=8'hFD: SHALL shift man_reg right by 1 and load exp_reg from exp_adj_result (add, amount 1, enable 1); stay in NORM.
REQ-017 NORM, bit24=1, exp_reg>=8'hFE: SHALL set exp_reg=8'hFF, man_reg=0 and overflow=1, then go to DONE.
REQ-018 NORM, bit24=0 and bit23=1: SHALL go to DONE with no change.
REQ-019 NORM, bit24=0, bit23=0, exp_reg>=2: SHALL shift left and load exp_reg from exp_adj_result (subtract, amount per REQ-026/027); stay in NORM.
REQ-020 NORM, bit24=0, bit23=0, exp_reg<=1: SHALL set exp_reg=0 without shifting, set underflow=1 and go to DONE.
REQ-021 In any cycle without a shift: exp_adj_enable=0, exp_adj_amount=0 and exp_adj_aluop=4'b0000.
REQ-022 DONE: SHALL copy exp_reg and man_reg to exponent_out and mantissa_out, assert done for exactly 1 cycle and return to IDLE.
REQ-023 Outputs SHALL hold until the next done; start SHALL be ignored while busy=1.
REQ-024 Latency: done SHALL be high in cycle k+2 after the start cycle, where k is the number of NORM shift cycles.
REQ-025 Exponent arithmetic SHALL be 8-bit modulo; a wrap SHALL be prevented by REQ-017 and REQ-020.

Reset
REQ-029 reset=1 SHALL immediately force IDLE and clear every output and register to 0 (exp_adj_aluop=4'b0000), including mid-NORM; no done pulse SHALL follow.

Configuration
REQ-026 With NORM_FAST_LZC_EN defined: each left-shift cycle SHALL shift by s = min(leading zeros of man_reg[23:0], exp_reg-1), with exp_adj_amount=s.
REQ-027 Without NORM_FAST_LZC_EN: each left-shift cycle SHALL shift by 1, with exp_adj_amount=1.

Verification
REQ-030 Scenario: mantissa 25'h0800000, exponent 8'h80 -> done in cycle 2; outputs 8'h80 and 25'h0800000; flags 0.
REQ-031 Scenario: mantissa 25'h1000000, exponent 8'h80 -> done in cycle 3; outputs 8'h81 and 25'h0800000.
REQ-032 Scenario: mantissa 25'h0000100, exponent 8'h80 -> outputs 8'h71 and 25'h0800000; done in cycle 17 without the macro, cycle 3 with it.
REQ-033 Scenario: mantissa 25'h1000000, exponent 8'hFE -> outputs 8'hFF and 0; overflow=1; done in cycle 2.
REQ-034 Scenario: mantissa 25'h0000001, exponent 8'h03 -> outputs 8'h00 and 25'h0000004; underflow=1; done in cycle 4 without the macro.
REQ-035 Scenario: reset pulse during cycle 5 of REQ-032 -> all outputs 0 and state IDLE; a new start then completes per REQ-030.

Source files
------------

// File: rtl/normalize_control.sv
// Floating-point normalization sequencer: IDLE/NORM/DONE, drives an external exponent adjust unit.
// Optional NORM_FAST_LZC_EN: multi-bit left shifts using a leading-zero count of man_reg[23:0].
module normalize_control (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  exponent_in,
  input  logic [24:0] mantissa_in,
  output logic [7:0]  exp_adj_value,
  output logic [7:0]  exp_adj_amount,
  output logic [3:0]  exp_adj_aluop,
  output logic        exp_adj_enable,
  input  logic [7:0]  exp_adj_result,
  output logic [7:0]  exponent_out,
  output logic [24:0] mantissa_out,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        underflow
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0011;

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  exp_reg, exp_nxt;
  logic [24:0] man_reg, man_nxt;
  logic        ovf_nxt, unf_nxt;
  logic        load_out;
  logic [4:0]  shamt;

`ifdef NORM_FAST_LZC_EN
  logic [4:0] lz;
  logic       found;
  logic [7:0] exp_m1;

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found) begin
        if (man_reg[i]) found = 1'b1;
        else            lz    = lz + 5'd1;
      end
    end
  end

  // Clamp so the exponent never drops below 1 by shifting; 0 is reserved for underflow.
  assign exp_m1 = exp_reg - 8'd1;
  assign shamt  = ({3'b000, lz} <= exp_m1) ? lz : exp_m1[4:0];
`else
  assign shamt = 5'd1;
`endif

  assign exp_adj_value = exp_reg;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  always_comb begin
    state_nxt      = state;
    exp_nxt        = exp_reg;
    man_nxt        = man_reg;
    ovf_nxt        = overflow;
    unf_nxt        = underflow;
    load_out       = 1'b0;
    exp_adj_amount = 8'd0;
    exp_adj_aluop  = ALU_ADD;
    exp_adj_enable = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          exp_nxt   = exponent_in;
          man_nxt   = mantissa_in;
          ovf_nxt   = 1'b0;
          unf_nxt   = 1'b0;
          state_nxt = NORM;
        end
      end
      NORM: begin
        if (man_reg == 25'd0) begin
          exp_nxt   = 8'd0;
          load_out  = 1'b1;
          state_nxt = DONE;
        end else if (man_reg[24]) begin
          if (exp_reg <= 8'hFD) begin
            man_nxt        = man_reg >> 1;
            exp_nxt        = exp_adj_result;
            exp_adj_amount = 8'd1;
            exp_adj_enable = 1'b1;
          end else begin
            exp_nxt   = 8'hFF;
            man_nxt   = 25'd0;
            ovf_nxt   = 1'b1;
            load_out  = 1'b1;
            state_nxt = DONE;
          end
        end else if (man_reg[23]) begin
          load_out  = 1'b1;
          state_nxt = DONE;
        end else if (exp_reg >= 8'd2) begin
          man_nxt        = man_reg << shamt;
          exp_nxt        = exp_adj_result;
          exp_adj_amount = {3'b000, shamt};
          exp_adj_aluop  = ALU_SUB;
          exp_adj_enable = 1'b1;
        end else begin
          exp_nxt   = 8'd0;
          unf_nxt   = 1'b1;
          load_out  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers load on entry to DONE so they are already valid while done is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      exp_reg      <= '0;
      man_reg      <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      exponent_out <= '0;
      mantissa_out <= '0;
    end else begin
      state     <= state_nxt;
      exp_reg   <= exp_nxt;
      man_reg   <= man_nxt;
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
      if (load_out) begin
        exponent_out <= exp_nxt;
        mantissa_out <= man_nxt;
      end
    end
  end

endmodule

// File: tb/tb_normalize_control.sv
// Scoreboard bench for normalize_control; honours NORM_FAST_LZC_EN for latency/amount expectations.
module tb_normalize_control;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  exponent_in;
  logic [24:0] mantissa_in;
  logic [7:0]  exp_adj_value, exp_adj_amount, exp_adj_result, exponent_out;
  logic [3:0]  exp_adj_aluop;
  logic        exp_adj_enable, busy, done, overflow, underflow;
  logic [24:0] mantissa_out;

  typedef struct {
    logic [7:0]  e;
    logic [24:0] m;
    logic        ovf;
    logic        unf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // External exponent increase/decrease unit
  assign exp_adj_result = (exp_adj_aluop == 4'b0011) ? exp_adj_value - exp_adj_amount
                                                     : exp_adj_value + exp_adj_amount;

  normalize_control dut (
    .clk(clk), .reset(reset), .start(start),
    .exponent_in(exponent_in), .mantissa_in(mantissa_in),
    .exp_adj_value(exp_adj_value), .exp_adj_amount(exp_adj_amount),
    .exp_adj_aluop(exp_adj_aluop), .exp_adj_enable(exp_adj_enable),
    .exp_adj_result(exp_adj_result),
    .exponent_out(exponent_out), .mantissa_out(mantissa_out),
    .busy(busy), .done(done), .overflow(overflow), .underflow(underflow)
  );

  // Reference normalizer, written from the algorithmic description.
  function automatic exp_t model(input logic [7:0] e0, input logic [24:0] m0);
    exp_t        r;
    logic [7:0]  e = e0;
    logic [24:0] m = m0;
    int          k = 0;
    int          s;
    r.ovf = 1'b0;
    r.unf = 1'b0;
    for (int it = 0; it < 64; it++) begin
      if (m == 0) begin
        e = 0;
        break;
      end else if (m[24]) begin
        if (e <= 8'hFD) begin
          m = m >> 1; e = e + 1; k++;
        end else begin
          e = 8'hFF; m = 0; r.ovf = 1'b1;
          break;
        end
      end else if (m[23]) begin
        break;
      end else if (e >= 2) begin
`ifdef NORM_FAST_LZC_EN
        s = 0;
        while (!m[23 - s]) s++;
        if (s > int'(e) - 1) s = int'(e) - 1;
`else
        s = 1;
`endif
        m = m << s; e = e - 8'(s); k++;
      end else begin
        e = 0; r.unf = 1'b1;
        break;
      end
    end
    r.e = e; r.m = m; r.lat = k + 2;
    return r;
  endfunction

  task automatic run_op(input logic [7:0] e, input logic [24:0] m, input exp_t ex,
                        input string nm, input bit poke);
    exp_t r;
    int   cnt = 0;
    bit   got = 0;
    sb.push_back(ex);
    exponent_in = e; mantissa_in = m; start = 1'b1;
    while (cnt < 64 && !got) begin
      @(posedge clk); #1;
      start = 1'b0;
      cnt++;
      if (poke && cnt == 1) begin
        start = 1'b1; exponent_in = 8'h11; mantissa_in = 25'h0000001;
      end
      if (done) got = 1;
    end
    start = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s timeout: no done within %0d cycles", nm, cnt);
      void'(sb.pop_front());
      return;
    end
    r = sb.pop_front();
    total++;
    if (cnt !== r.lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", nm, cnt, r.lat); end
    total++;
    if (exponent_out !== r.e) begin bad++; $display("FAIL %s exponent: got %h want %h", nm, exponent_out, r.e); end
    total++;
    if (mantissa_out !== r.m) begin bad++; $display("FAIL %s mantissa: got %h want %h", nm, mantissa_out, r.m); end
    total++;
    if (overflow !== r.ovf) begin bad++; $display("FAIL %s overflow: got %b want %b", nm, overflow, r.ovf); end
    total++;
    if (underflow !== r.unf) begin bad++; $display("FAIL %s underflow: got %b want %b", nm, underflow, r.unf); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_in_done: got %b want 1", nm, busy); end
    @(posedge clk); #1;
    total++;
    if ({done, busy} !== 2'b00) begin bad++; $display("FAIL %s done_one_cycle: got done=%b busy=%b want 0 0", nm, done, busy); end
    total++;
    if (exponent_out !== r.e || mantissa_out !== r.m) begin
      bad++; $display("FAIL %s hold: got %h/%h want %h/%h", nm, exponent_out, mantissa_out, r.e, r.m);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; exponent_in = '0; mantissa_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    total++;
    if ({busy, done, overflow, underflow, exp_adj_enable} !== 5'b0 ||
        exponent_out !== 8'd0 || mantissa_out !== 25'd0 || exp_adj_value !== 8'd0 ||
        exp_adj_amount !== 8'd0 || exp_adj_aluop !== 4'b0000) begin
      bad++; $display("FAIL reset_state: got busy=%b done=%b eo=%h mo=%h val=%h amt=%h op=%h want all 0",
                      busy, done, exponent_out, mantissa_out, exp_adj_value, exp_adj_amount, exp_adj_aluop);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_scenarios();
    exp_t x;
    x = '{8'h80, 25'h0800000, 1'b0, 1'b0, 2};  run_op(8'h80, 25'h0800000, x, "normalized", 0);
    x = '{8'h81, 25'h0800000, 1'b0, 1'b0, 3};  run_op(8'h80, 25'h1000000, x, "carry", 0);
`ifdef NORM_FAST_LZC_EN
    x = '{8'h71, 25'h0800000, 1'b0, 1'b0, 3};  run_op(8'h80, 25'h0000100, x, "left15", 1);
    x = '{8'h00, 25'h0000004, 1'b0, 1'b1, 3};  run_op(8'h03, 25'h0000001, x, "underflow", 0);
`else
    x = '{8'h71, 25'h0800000, 1'b0, 1'b0, 17}; run_op(8'h80, 25'h0000100, x, "left15", 1);
    x = '{8'h00, 25'h0000004, 1'b0, 1'b1, 4};  run_op(8'h03, 25'h0000001, x, "underflow", 0);
`endif
    x = '{8'hFF, 25'h0000000, 1'b1, 1'b0, 2};  run_op(8'hFE, 25'h1000000, x, "overflow", 0);
    x = '{8'hFE, 25'h0800000, 1'b0, 1'b0, 3};  run_op(8'hFD, 25'h1000000, x, "carry_fd", 0);
    x = '{8'h00, 25'h0000000, 1'b0, 1'b0, 2};  run_op(8'h55, 25'h0000000, x, "zero", 0);
    x = '{8'h00, 25'h0400000, 1'b0, 1'b1, 2};  run_op(8'h01, 25'h0400000, x, "exp1_unf", 0);
    x = '{8'h01, 25'h0800000, 1'b0, 1'b0, 3};  run_op(8'h02, 25'h0400000, x, "exp2_shift", 0);
  endtask

  task automatic test_adj_port();
    int cnt = 0;
    exponent_in = 8'h80; mantissa_in = 25'h0000100; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    total++;
`ifdef NORM_FAST_LZC_EN
    if ({exp_adj_enable, exp_adj_aluop, exp_adj_amount, exp_adj_value} !== {1'b1, 4'b0011, 8'd15, 8'h80}) begin
`else
    if ({exp_adj_enable, exp_adj_aluop, exp_adj_amount, exp_adj_value} !== {1'b1, 4'b0011, 8'd1, 8'h80}) begin
`endif
      bad++; $display("FAIL adj_left: got en=%b op=%h amt=%h val=%h", exp_adj_enable, exp_adj_aluop, exp_adj_amount, exp_adj_value);
    end
    while (!done && cnt < 64) begin @(posedge clk); #1; cnt++; end
    total++;
    if ({exp_adj_enable, exp_adj_aluop, exp_adj_amount} !== 13'd0) begin
      bad++; $display("FAIL adj_idle_in_done: got en=%b op=%h amt=%h want 0", exp_adj_enable, exp_adj_aluop, exp_adj_amount);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    exp_t x;
    int   late = 0;
    exponent_in = 8'h80; mantissa_in = 25'h0000100; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({busy, done, overflow, underflow, exp_adj_enable} !== 5'b0 ||
        exponent_out !== 8'd0 || mantissa_out !== 25'd0 || exp_adj_value !== 8'd0 ||
        exp_adj_amount !== 8'd0 || exp_adj_aluop !== 4'b0000) begin
      bad++; $display("FAIL mid_reset: got busy=%b done=%b eo=%h mo=%h val=%h amt=%h want all 0",
                      busy, done, exponent_out, mantissa_out, exp_adj_value, exp_adj_amount);
    end
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (done || busy) late++; end
    total++;
    if (late !== 0) begin bad++; $display("FAIL no_done_after_reset: got %0d active cycles want 0", late); end
    x = '{8'h80, 25'h0800000, 1'b0, 1'b0, 2};
    run_op(8'h80, 25'h0800000, x, "after_reset", 0);
  endtask

  task automatic test_random();
    logic [7:0]  e;
    logic [24:0] m;
    for (int i = 0; i < 24; i++) begin
      e = 8'($urandom_range(0, 255));
      m = 25'($urandom) >> $urandom_range(0, 25);
      run_op(e, m, model(e, m), "random", i[0]);
    end
  endtask

  initial begin
    test_reset();
    test_scenarios();
    test_adj_port();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
